// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one CPU data request at a time, stalls it
// for a configurable number of wait states, validates the address, then
// commits the write or returns the read word with a one-cycle ready pulse.
module dmem_responder #(
  parameter int          ADDR_WORDS  = 256,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_data,
  input  logic        dmem_wen,
  input  logic        dmem_ren,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        dmem_err,
  output logic        dmem_busy,
  output logic [15:0] wr_count
);

  localparam int          IDX_W      = $clog2(ADDR_WORDS);
  localparam logic [31:0] SPAN_BYTES = 32'(ADDR_WORDS * 4);
  // The acceptance cycle is itself a busy cycle, so the counter is loaded
  // one higher than the number of extra wait states.
  localparam logic [4:0]  CNT_LOAD   = 5'(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [4:0]        cnt;
  logic [31:0]       req_addr;
  logic [31:0]       req_data;
  logic              req_write;
  logic [31:0]       offset;
  logic              req_err;
  logic              accept;
  logic              commit;
  logic [IDX_W-1:0]  idx;
  logic [31:0]       mem [ADDR_WORDS];

  assign offset    = req_addr - BASE_ADDR;
  assign req_err   = (req_addr[1:0] != 2'b00) || (offset >= SPAN_BYTES);
  assign idx       = offset[IDX_W+1:2];
  assign accept    = (state == IDLE) && (dmem_wen || dmem_ren);
  assign commit    = (state == WAIT) && (cnt == 5'd1);
  assign dmem_busy = (state != IDLE);

  // Next-state logic: IDLE -> WAIT on a request, WAIT -> RESP when the
  // wait counter expires, RESP always returns to IDLE after one cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (dmem_wen || dmem_ren) state_next = WAIT;
      WAIT:    if (cnt == 5'd1) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register, request latch, wait counter and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 5'd0;
      req_addr   <= 32'd0;
      req_data   <= 32'd0;
      req_write  <= 1'b0;
      dmem_ready <= 1'b0;
      dmem_err   <= 1'b0;
      dmem_rdata <= 32'd0;
      wr_count   <= 16'd0;
    end else begin
      state      <= state_next;
      dmem_ready <= commit;
      dmem_err   <= commit && req_err;
      if (accept) begin
        req_addr  <= dmem_addr;
        req_data  <= dmem_data;
        req_write <= dmem_wen;
        cnt       <= CNT_LOAD;
      end else if (state == WAIT) begin
        cnt <= cnt - 5'd1;
      end
      if (commit) begin
        if (req_err) begin
          dmem_rdata <= 32'd0;
        end else if (req_write) begin
          if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
        end else begin
          dmem_rdata <= mem[idx];
        end
      end
    end
  end

  // Word array write port; contents survive reset, and a reset arriving on
  // what would have been the commit edge discards the pending write.
  always_ff @(posedge clk) begin
    if (!rst && commit && req_write && !req_err) mem[idx] <= req_data;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder. Three instances cover
// WAIT_CYCLES = 1, 0 and 4; slot 0/1/2 of each signal array belongs to them.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        wen   [3];
  logic        ren   [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic        ready [3];
  logic        err   [3];
  logic        busy  [3];
  logic [15:0] wcnt  [3];

  int total = 0;
  int bad   = 0;

  dmem_responder #(.ADDR_WORDS(256), .WAIT_CYCLES(1), .BASE_ADDR(32'h0)) dut_w1 (
    .clk(clk), .rst(rst), .dmem_addr(addr[0]), .dmem_data(wdata[0]),
    .dmem_wen(wen[0]), .dmem_ren(ren[0]), .dmem_rdata(rdata[0]),
    .dmem_ready(ready[0]), .dmem_err(err[0]), .dmem_busy(busy[0]),
    .wr_count(wcnt[0]));

  dmem_responder #(.ADDR_WORDS(256), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut_w0 (
    .clk(clk), .rst(rst), .dmem_addr(addr[1]), .dmem_data(wdata[1]),
    .dmem_wen(wen[1]), .dmem_ren(ren[1]), .dmem_rdata(rdata[1]),
    .dmem_ready(ready[1]), .dmem_err(err[1]), .dmem_busy(busy[1]),
    .wr_count(wcnt[1]));

  dmem_responder #(.ADDR_WORDS(256), .WAIT_CYCLES(4), .BASE_ADDR(32'h0)) dut_w4 (
    .clk(clk), .rst(rst), .dmem_addr(addr[2]), .dmem_data(wdata[2]),
    .dmem_wen(wen[2]), .dmem_ren(ren[2]), .dmem_rdata(rdata[2]),
    .dmem_ready(ready[2]), .dmem_err(err[2]), .dmem_busy(busy[2]),
    .wr_count(wcnt[2]));

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence itself stalls.
  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got=running expected=finished");
    $fatal(1, "[TB] global timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive one request on instance idx and wait for its ready pulse. lat
  // counts rising edges from acceptance (edge 1) to the edge after which
  // ready is seen. When scramble is set the inputs change during WAIT.
  task automatic applyStimulus(input int idx, input logic w, input logic r,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic scramble, output int lat,
                               output logic [31:0] rd, output logic er,
                               output logic busy_ok);
    lat     = 0;
    busy_ok = 1'b1;
    rd      = 32'd0;
    er      = 1'b0;
    @(negedge clk);
    wen[idx]   = w;
    ren[idx]   = r;
    addr[idx]  = a;
    wdata[idx] = d;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (scramble && lat == 1) begin
        addr[idx]  = a + 32'd4;
        wdata[idx] = ~d;
      end
      if (ready[idx]) break;
      if (!busy[idx]) busy_ok = 1'b0;
    end
    if (!ready[idx]) begin
      checkOutput("ready_timeout", 32'd0, 32'd1);
    end else begin
      rd = rdata[idx];
      er = err[idx];
      if (!busy[idx]) busy_ok = 1'b0;
    end
    wen[idx] = 1'b0;
    ren[idx] = 1'b0;
  endtask

  // One request plus the standard checks on its response.
  task automatic runReq(input string tag, input int idx, input logic w, input logic r,
                        input logic [31:0] a, input logic [31:0] d, input logic scramble,
                        input int exp_lat, input logic exp_err,
                        input logic chk_rd, input logic [31:0] exp_rd);
    int          lat;
    logic [31:0] rd;
    logic        er;
    logic        bok;
    applyStimulus(idx, w, r, a, d, scramble, lat, rd, er, bok);
    checkOutput({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
    checkOutput({tag, "_busy"}, {31'd0, bok}, 32'd1);
    if (chk_rd) checkOutput({tag, "_rdata"}, rd, exp_rd);
    @(posedge clk);
    #1;
    checkOutput({tag, "_pulse_end"}, {29'd0, ready[idx], err[idx], busy[idx]}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wen[i] = 1'b0; ren[i] = 1'b0; addr[i] = 32'd0; wdata[i] = 32'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("rst_flags", {29'd0, ready[i], err[i], busy[i]}, 32'd0);
      checkOutput("rst_rdata", rdata[i], 32'd0);
      checkOutput("rst_wcnt", {16'd0, wcnt[i]}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] basic write/read, WAIT_CYCLES=1");
    runReq("w1_wr10", 0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 3, 1'b0, 1'b0, 32'd0);
    checkOutput("w1_wcnt1", {16'd0, wcnt[0]}, 32'd1);
    runReq("w1_rd10", 0, 1'b0, 1'b1, 32'h10, 32'd0, 1'b0, 3, 1'b0, 1'b1, 32'hDEADBEEF);
    checkOutput("w1_rdata_held", rdata[0], 32'hDEADBEEF);

    $display("[TB] wait-state sweep");
    runReq("w0_wr", 1, 1'b1, 1'b0, 32'h8, 32'h11112222, 1'b0, 2, 1'b0, 1'b0, 32'd0);
    runReq("w0_rd", 1, 1'b0, 1'b1, 32'h8, 32'd0, 1'b0, 2, 1'b0, 1'b1, 32'h11112222);
    checkOutput("w0_wcnt", {16'd0, wcnt[1]}, 32'd1);
    runReq("w4_wr", 2, 1'b1, 1'b0, 32'h4, 32'h33334444, 1'b0, 6, 1'b0, 1'b0, 32'd0);
    runReq("w4_rd", 2, 1'b0, 1'b1, 32'h4, 32'd0, 1'b0, 6, 1'b0, 1'b1, 32'h33334444);

    $display("[TB] address errors and range edges");
    runReq("err_wr13", 0, 1'b1, 1'b0, 32'h13, 32'hFFFFFFFF, 1'b0, 3, 1'b1, 1'b1, 32'd0);
    checkOutput("err_wr13_wcnt", {16'd0, wcnt[0]}, 32'd1);
    runReq("err_rd10", 0, 1'b0, 1'b1, 32'h10, 32'd0, 1'b0, 3, 1'b0, 1'b1, 32'hDEADBEEF);
    runReq("err_rd400", 0, 1'b0, 1'b1, 32'h400, 32'd0, 1'b0, 3, 1'b1, 1'b1, 32'd0);
    runReq("err_rdneg", 0, 1'b0, 1'b1, 32'hFFFFFFFC, 32'd0, 1'b0, 3, 1'b1, 1'b1, 32'd0);
    runReq("top_wr3fc", 0, 1'b1, 1'b0, 32'h3FC, 32'hCAFEF00D, 1'b0, 3, 1'b0, 1'b0, 32'd0);
    runReq("top_rd3fc", 0, 1'b0, 1'b1, 32'h3FC, 32'd0, 1'b0, 3, 1'b0, 1'b1, 32'hCAFEF00D);
    checkOutput("top_wcnt", {16'd0, wcnt[0]}, 32'd2);

    $display("[TB] priority and input stability");
    runReq("prio_wr20", 0, 1'b1, 1'b1, 32'h20, 32'h55, 1'b0, 3, 1'b0, 1'b0, 32'd0);
    checkOutput("prio_wcnt", {16'd0, wcnt[0]}, 32'd3);
    runReq("prio_rd20", 0, 1'b0, 1'b1, 32'h20, 32'd0, 1'b0, 3, 1'b0, 1'b1, 32'h55);
    runReq("stab_pre34", 2, 1'b1, 1'b0, 32'h34, 32'h99, 1'b0, 6, 1'b0, 1'b0, 32'd0);
    runReq("stab_wr30", 2, 1'b1, 1'b0, 32'h30, 32'h77, 1'b1, 6, 1'b0, 1'b0, 32'd0);
    runReq("stab_rd30", 2, 1'b0, 1'b1, 32'h30, 32'd0, 1'b0, 6, 1'b0, 1'b1, 32'h77);
    runReq("stab_rd34", 2, 1'b0, 1'b1, 32'h34, 32'd0, 1'b0, 6, 1'b0, 1'b1, 32'h99);
    checkOutput("stab_wcnt", {16'd0, wcnt[2]}, 32'd3);

    $display("[TB] reset during WAIT");
    runReq("mid_pre40", 2, 1'b1, 1'b0, 32'h40, 32'hAAAA0000, 1'b0, 6, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    wen[2] = 1'b1; addr[2] = 32'h40; wdata[2] = 32'h1234;
    @(posedge clk);
    @(negedge clk);
    wen[2] = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid_flags", {30'd0, ready[2], busy[2]}, 32'd0);
    checkOutput("mid_wcnt", {16'd0, wcnt[2]}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    runReq("mid_rd40", 2, 1'b0, 1'b1, 32'h40, 32'd0, 1'b0, 6, 1'b0, 1'b1, 32'hAAAA0000);

    $display("[TB] write counter saturation");
    @(negedge clk);
    force dut_w1.wr_count = 16'hFFFE;
    @(negedge clk);
    release dut_w1.wr_count;
    runReq("sat_wr50", 0, 1'b1, 1'b0, 32'h50, 32'h1, 1'b0, 3, 1'b0, 1'b0, 32'd0);
    checkOutput("sat_wcnt_ffff", {16'd0, wcnt[0]}, 32'h0000FFFF);
    runReq("sat_wr54", 0, 1'b1, 1'b0, 32'h54, 32'h2, 1'b0, 3, 1'b0, 1'b0, 32'd0);
    checkOutput("sat_wcnt_hold", {16'd0, wcnt[0]}, 32'h0000FFFF);
    runReq("sat_rd54", 0, 1'b0, 1'b1, 32'h54, 32'd0, 1'b0, 3, 1'b0, 1'b1, 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
